// File: rtl/exp7_sequenciador_jogo_if.sv
// Control/status bundle between the game sequencer and its datapath.
// Carries player inputs, datapath flags, counter controls and end-of-game flags.
interface exp7_sequenciador_jogo_if;
    logic       jogar;
    logic       jogada;
    logic       jogada_correta;
    logic       enderecoIgualRodada;
    logic       fimR;
    logic       zeraE;
    logic       contaE;
    logic       zeraR;
    logic       contaR;
    logic       registraRC;
    logic       leds_en;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic [4:0] db_estado;

    modport master (
        input  jogar, jogada, jogada_correta, enderecoIgualRodada, fimR,
        output zeraE, contaE, zeraR, contaR, registraRC, leds_en,
        output pronto, ganhou, perdeu, timeout, db_estado
    );

    modport slave (
        output jogar, jogada, jogada_correta, enderecoIgualRodada, fimR,
        input  zeraE, contaE, zeraR, contaR, registraRC, leds_en,
        input  pronto, ganhou, perdeu, timeout, db_estado
    );
endinterface

// File: rtl/exp7_sequenciador_jogo.sv
// Moore sequencer for the memory game: replays the sequence, collects moves, reports outcome (TIMEOUT_EN enables move timeout).
// Latency: outputs are decoded from the state register, so they change one cycle after the causing input.
// Backpressure: none; jogada is a one-cycle pulse sampled only in ESPERA, jogar only when idle or finished.
module exp7_sequenciador_jogo #(
    parameter int T_ON      = 500,
    parameter int T_OFF     = 250,
    parameter int T_TIMEOUT = 5000
) (
    input  logic                        clock,
    input  logic                        reset,
    exp7_sequenciador_jogo_if.master    bus
);

    localparam int T_DISP = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int T_MAX  = (T_DISP > T_TIMEOUT) ? T_DISP : T_TIMEOUT;
    localparam int TW     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [4:0] {
        INICIAL       = 5'h00,
        PREPARA       = 5'h01,
        MOSTRA        = 5'h02,
        APAGA         = 5'h03,
        PROX_MOSTRA   = 5'h04,
        INICIO_JOGADA = 5'h05,
        ESPERA        = 5'h06,
        REGISTRA      = 5'h07,
        COMPARA       = 5'h08,
        PROX_JOGADA   = 5'h09,
        PROX_RODADA   = 5'h0A,
        FIM_GANHOU    = 5'h0B,
        FIM_PERDEU    = 5'h0C,
        FIM_TIMEOUT   = 5'h0D
    } estado_t;

    estado_t       estado, estado_prox;
    logic [TW-1:0] timer;
    logic          fim_on, fim_off;

    assign fim_on  = (timer == TW'(T_ON - 1));
    assign fim_off = (timer == TW'(T_OFF - 1));
`ifdef TIMEOUT_EN
    logic fim_to;
    assign fim_to = (timer == TW'(T_TIMEOUT - 1));
`endif

    // The timer measures time spent in the current state; any state change restarts it.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
            timer  <= '0;
        end else begin
            estado <= estado_prox;
            timer  <= (estado_prox != estado) ? '0 : timer + TW'(1);
        end
    end

    always_comb begin
        estado_prox    = estado;
        bus.zeraE      = 1'b0;
        bus.contaE     = 1'b0;
        bus.zeraR      = 1'b0;
        bus.contaR     = 1'b0;
        bus.registraRC = 1'b0;
        bus.leds_en    = 1'b0;
        bus.pronto     = 1'b0;
        bus.ganhou     = 1'b0;
        bus.perdeu     = 1'b0;
        bus.timeout    = 1'b0;
        case (estado)
            INICIAL: if (bus.jogar) estado_prox = PREPARA;
            PREPARA: begin
                bus.zeraE   = 1'b1;
                bus.zeraR   = 1'b1;
                estado_prox = MOSTRA;
            end
            MOSTRA: begin
                bus.leds_en = 1'b1;
                if (fim_on) estado_prox = APAGA;
            end
            APAGA: if (fim_off)
                estado_prox = bus.enderecoIgualRodada ? INICIO_JOGADA : PROX_MOSTRA;
            PROX_MOSTRA: begin
                bus.contaE  = 1'b1;
                estado_prox = MOSTRA;
            end
            INICIO_JOGADA: begin
                bus.zeraE   = 1'b1;
                estado_prox = ESPERA;
            end
            ESPERA: begin
                // A press on the expiry cycle still counts as a move.
                if (bus.jogada) estado_prox = REGISTRA;
`ifdef TIMEOUT_EN
                else if (fim_to) estado_prox = FIM_TIMEOUT;
`endif
            end
            REGISTRA: begin
                bus.registraRC = 1'b1;
                estado_prox    = COMPARA;
            end
            COMPARA: begin
                if (!bus.jogada_correta)           estado_prox = FIM_PERDEU;
                else if (!bus.enderecoIgualRodada) estado_prox = PROX_JOGADA;
                else if (bus.fimR)                 estado_prox = FIM_GANHOU;
                else                               estado_prox = PROX_RODADA;
            end
            PROX_JOGADA: begin
                bus.contaE  = 1'b1;
                estado_prox = ESPERA;
            end
            PROX_RODADA: begin
                bus.contaR  = 1'b1;
                bus.zeraE   = 1'b1;
                estado_prox = MOSTRA;
            end
            FIM_GANHOU: begin
                bus.pronto = 1'b1;
                bus.ganhou = 1'b1;
                if (bus.jogar) estado_prox = PREPARA;
            end
            FIM_PERDEU: begin
                bus.pronto = 1'b1;
                bus.perdeu = 1'b1;
                if (bus.jogar) estado_prox = PREPARA;
            end
            FIM_TIMEOUT: begin
                bus.pronto = 1'b1;
                bus.perdeu = 1'b1;
`ifdef TIMEOUT_EN
                bus.timeout = 1'b1;
`endif
                if (bus.jogar) estado_prox = PREPARA;
            end
            default: estado_prox = INICIAL;
        endcase
    end

    assign bus.db_estado = estado;

endmodule
